uart_rx_deserializer: RTL

UART receive deserializer. Consumes the 16x oversampling enable produced by the baud-rate divider counter and the raw serial input, then recovers one character per frame with parity, framing and break status. It sits directly downstream of the baud counter and upstream of the receive FIFO, which is written on RXFINISHED.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_rx_majority.sv | 30 +++
 rtl/uart_rx_deserializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types, constants and helpers for the UART receive deserializer.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, MWAIT} rx_state_t;

    typedef struct packed {
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic       sp;
    } rx_cfg_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam logic [3:0] SAMPLE_TICK = 4'd8;
    localparam logic [3:0] LAST_TICK   = 4'd15;

    function automatic logic [2:0] last_bit(input logic [1:0] wls);
        return wls == WLS_5 ? 3'd4 : wls == WLS_6 ? 3'd5 : wls == WLS_7 ? 3'd6 : 3'd7;
    endfunction

    function automatic logic exp_parity(input logic [7:0] d, input logic eps, input logic sp);
        return sp ? ~eps : (eps ? ^d : ~^d);
    endfunction

endpackage

// File: rtl/uart_rx_majority.sv
// uart_rx_majority: SIN synchronizer plus a 3-sample majority vote advanced by RXCLK.
module uart_rx_majority (
    input  logic CLK,
    input  logic RST,
    input  logic RXCLK,
    input  logic SIN,
    output logic sync,
    output logic maj
);

    logic       s1;
    logic [1:0] hist;

    // The vote window is the two stored samples plus the current synchronized value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1   <= 1'b1;
            sync <= 1'b1;
            hist <= 2'b11;
        end else begin
            s1   <= SIN;
            sync <= s1;
            if (RXCLK)
                hist <= {hist[0], sync};
        end
    end

    assign maj = (hist[1] & hist[0]) | (hist[1] & sync) | (hist[0] & sync);

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: recovers one UART character per frame with parity, framing and break status.
module uart_rx_deserializer
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXCLK,
    input  logic       CLEAR,
    input  logic [1:0] WLS,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       SIN,
    output logic [7:0] DOUT,
    output logic       PE,
    output logic       FE,
    output logic       BI,
    output logic       RXFINISHED
);

    rx_state_t  state, state_n;
    rx_cfg_t    cfg, cfg_n;
    logic [3:0] tick, tick_n, nt;
    logic [2:0] bitcnt, bitcnt_n;
    logic [7:0] shadow, shadow_n, dout_n;
    logic       parbit, parbit_n;
    logic       pe_n, fe_n, bi_n, fin_n;
    logic       sync, maj;

    uart_rx_majority u_maj (
        .CLK   (CLK),
        .RST   (RST),
        .RXCLK (RXCLK),
        .SIN   (SIN),
        .sync  (sync),
        .maj   (maj)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cfg        <= '0;
            tick       <= '0;
            bitcnt     <= '0;
            shadow     <= '0;
            parbit     <= 1'b0;
            DOUT       <= '0;
            PE         <= 1'b0;
            FE         <= 1'b0;
            BI         <= 1'b0;
            RXFINISHED <= 1'b0;
        end else begin
            state      <= state_n;
            cfg        <= cfg_n;
            tick       <= tick_n;
            bitcnt     <= bitcnt_n;
            shadow     <= shadow_n;
            parbit     <= parbit_n;
            DOUT       <= dout_n;
            PE         <= pe_n;
            FE         <= fe_n;
            BI         <= bi_n;
            RXFINISHED <= fin_n;
        end
    end

    assign nt = tick + 4'd1;

    always_comb begin
        state_n  = state;
        cfg_n    = cfg;
        tick_n   = tick;
        bitcnt_n = bitcnt;
        shadow_n = shadow;
        parbit_n = parbit;
        dout_n   = DOUT;
        pe_n     = PE;
        fe_n     = FE;
        bi_n     = BI;
        fin_n    = 1'b0;
        if (CLEAR) begin
            state_n  = IDLE;
            tick_n   = '0;
            bitcnt_n = '0;
        end else if (RXCLK) begin
            case (state)
                IDLE: if (!sync) begin
                    state_n  = START;
                    tick_n   = '0;
                    bitcnt_n = '0;
                    shadow_n = '0;
                    parbit_n = 1'b0;
                    cfg_n    = '{WLS, PEN, EPS, SP};
                end
                MWAIT: if (maj) state_n = IDLE;
                default: begin
                    tick_n = nt;
                    if (nt == SAMPLE_TICK) begin
                        case (state)
                            START: if (maj) begin
                                state_n = IDLE;
                                tick_n  = '0;
                            end
                            DATA: shadow_n[bitcnt] = maj;
                            PAR:  parbit_n = maj;
                            STOP: begin
                                dout_n  = shadow;
                                pe_n    = cfg.pen & (parbit != exp_parity(shadow, cfg.eps, cfg.sp));
                                fe_n    = ~maj;
                                bi_n    = (shadow == 8'd0) & (~parbit | ~cfg.pen) & ~maj;
                                fin_n   = 1'b1;
                                state_n = maj ? IDLE : MWAIT;
                                tick_n  = '0;
                            end
                            default: ;
                        endcase
                    end
                    if (tick == LAST_TICK) begin
                        case (state)
                            START: begin
                                state_n  = DATA;
                                bitcnt_n = '0;
                            end
                            DATA: begin
                                state_n  = bitcnt == last_bit(cfg.wls) ? (cfg.pen ? PAR : STOP) : DATA;
                                bitcnt_n = bitcnt + 3'd1;
                            end
                            PAR: state_n = STOP;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
